// File: rtl/if_id_stage.sv
// if_id_stage: program counter, instruction fetch and IF/ID pipeline register
module if_id_stage #(
    parameter int               XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_PC  = '0,
    parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_write,
    input  logic            if_id_write,
    input  logic            if_id_flush,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_pc4,
    output logic [31:0]     if_id_instr,
    output logic            if_id_valid,
    output logic [4:0]      if_id_rs1,
    output logic [4:0]      if_id_rs2
);
    logic [XLEN-1:0] pc_q, pc_d, pc_plus4;
    logic [XLEN-1:0] id_pc_q, id_pc_d, id_pc4_q, id_pc4_d;
    logic [31:0]     id_instr_q, id_instr_d;
    logic            id_valid_q, id_valid_d;
    logic            kill, load;

    assign pc_plus4 = pc_q + XLEN'(4);
    assign kill     = if_id_flush | branch_taken;
    assign load     = kill | if_id_write;

    // Next-state selection: a redirect beats a stall because it comes from an older instruction
    always_comb begin
        pc_d       = branch_taken ? (branch_target & ~XLEN'(3)) : pc_write ? pc_plus4 : pc_q;
        id_instr_d = kill ? NOP_INSTR : if_id_write ? imem_rdata : id_instr_q;
        id_valid_d = kill ? 1'b0 : if_id_write ? 1'b1 : id_valid_q;
        id_pc_d    = load ? pc_q : id_pc_q;
        id_pc4_d   = load ? pc_plus4 : id_pc4_q;
    end

    // PC and IF/ID state update with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            id_instr_q <= NOP_INSTR;
            id_pc_q    <= '0;
            id_pc4_q   <= '0;
            id_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
            id_pc4_q   <= id_pc4_d;
            id_valid_q <= id_valid_d;
        end
    end

    assign imem_addr   = pc_q;
    assign if_id_pc    = id_pc_q;
    assign if_id_pc4   = id_pc4_q;
    assign if_id_instr = id_instr_q;
    assign if_id_valid = id_valid_q;
    assign if_id_rs1   = id_instr_q[19:15];
    assign if_id_rs2   = id_instr_q[24:20];
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: directed and randomized checks of if_id_stage against a reference model
module tb_if_id_stage;
    localparam logic [31:0] K   = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, pc_write, if_id_write, if_id_flush, branch_taken;
    logic [31:0] branch_target, imem_addr, imem_rdata, if_id_pc, if_id_pc4, if_id_instr;
    logic        if_id_valid;
    logic [4:0]  if_id_rs1, if_id_rs2;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc, m_instr, m_idpc, m_idpc4;
    logic        m_v;

    if_id_stage dut (
        .clk(clk), .rst(rst), .pc_write(pc_write), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .if_id_pc(if_id_pc),
        .if_id_pc4(if_id_pc4), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
        .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2)
    );

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr ^ K;

    task automatic tick(input logic r, pw, iw, fl, bt, input logic [31:0] tgt);
        logic [31:0] old;
        rst = r; pc_write = pw; if_id_write = iw; if_id_flush = fl;
        branch_taken = bt; branch_target = tgt;
        @(posedge clk);
        if (r) begin
            m_pc = 32'h0; m_instr = NOP; m_idpc = 0; m_idpc4 = 0; m_v = 1'b0;
        end else begin
            old = m_pc;
            if (fl || bt) begin
                m_instr = NOP; m_v = 1'b0; m_idpc = old; m_idpc4 = old + 32'd4;
            end else if (iw) begin
                m_instr = old ^ K; m_v = 1'b1; m_idpc = old; m_idpc4 = old + 32'd4;
            end
            m_pc = bt ? {tgt[31:2], 2'b00} : pw ? old + 32'd4 : old;
        end
        #1;
    endtask

    task automatic test_reset;
        tick(1, 1, 1, 0, 0, 0);
        tick(1, 1, 1, 0, 0, 0);
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h exp %h", imem_addr, 32'h0); end
        checks++; if (if_id_instr !== NOP) begin errors++; $display("FAIL reset_instr: got %h exp %h", if_id_instr, NOP); end
        checks++; if (if_id_pc !== 32'h0 || if_id_pc4 !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h/%h exp 0/0", if_id_pc, if_id_pc4); end
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", if_id_valid); end
        checks++; if (if_id_rs1 !== 5'd0 || if_id_rs2 !== 5'd0) begin errors++; $display("FAIL reset_rs: got %0d/%0d exp 0/0", if_id_rs1, if_id_rs2); end
    endtask

    task automatic test_seq_fetch;
        for (int k = 1; k <= 2; k++) begin
            tick(0, 1, 1, 0, 0, 0);
            checks++; if (imem_addr !== 32'(4 * k)) begin errors++; $display("FAIL seq_addr: got %h exp %h", imem_addr, 32'(4 * k)); end
            checks++; if (if_id_pc !== 32'(4 * (k - 1)) || if_id_pc4 !== 32'(4 * k)) begin errors++; $display("FAIL seq_pc: got %h/%h exp %h/%h", if_id_pc, if_id_pc4, 32'(4 * (k - 1)), 32'(4 * k)); end
            checks++; if (if_id_instr !== (32'(4 * (k - 1)) ^ K) || if_id_valid !== 1'b1) begin errors++; $display("FAIL seq_instr: got %h v%b exp %h v1", if_id_instr, if_id_valid, 32'(4 * (k - 1)) ^ K); end
        end
    endtask

    task automatic test_stall;
        for (int k = 0; k < 2; k++) begin
            tick(0, 0, 0, 0, 0, 0);
            checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL stall_addr: got %h exp %h", imem_addr, 32'h8); end
            checks++; if (if_id_pc !== 32'h4 || if_id_instr !== (32'h4 ^ K) || if_id_valid !== 1'b1) begin errors++; $display("FAIL stall_hold: got pc %h instr %h v%b exp pc 4 instr %h v1", if_id_pc, if_id_instr, if_id_valid, 32'h4 ^ K); end
        end
        tick(0, 1, 1, 0, 0, 0);
        checks++; if (imem_addr !== 32'hC || if_id_pc !== 32'h8) begin errors++; $display("FAIL stall_resume: got addr %h pc %h exp c/8", imem_addr, if_id_pc); end
    endtask

    task automatic test_branch;
        tick(0, 1, 1, 0, 0, 0);
        checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL br_pre: got %h exp %h", imem_addr, 32'h10); end
        tick(0, 1, 1, 0, 1, 32'h0000_0103);
        checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL br_addr: got %h exp %h", imem_addr, 32'h100); end
        checks++; if (if_id_instr !== NOP || if_id_valid !== 1'b0) begin errors++; $display("FAIL br_bubble: got %h v%b exp %h v0", if_id_instr, if_id_valid, NOP); end
        checks++; if (if_id_pc !== m_idpc || if_id_pc4 !== m_idpc4) begin errors++; $display("FAIL br_pc_det: got %h/%h exp %h/%h", if_id_pc, if_id_pc4, m_idpc, m_idpc4); end
        tick(0, 1, 1, 0, 0, 0);
        checks++; if (if_id_pc !== 32'h100 || if_id_valid !== 1'b1 || if_id_instr !== (32'h100 ^ K)) begin errors++; $display("FAIL br_target: got pc %h v%b instr %h exp 100 v1 %h", if_id_pc, if_id_valid, if_id_instr, 32'h100 ^ K); end
    endtask

    task automatic test_stall_branch;
        tick(0, 0, 0, 0, 1, 32'h200);
        checks++; if (imem_addr !== 32'h200 || if_id_valid !== 1'b0 || if_id_instr !== NOP) begin errors++; $display("FAIL stbr: got addr %h v%b instr %h exp 200 v0 %h", imem_addr, if_id_valid, if_id_instr, NOP); end
        tick(0, 1, 1, 0, 0, 0);
        checks++; if (if_id_pc !== 32'h200 || if_id_pc4 !== 32'h204) begin errors++; $display("FAIL stbr_next: got %h/%h exp 200/204", if_id_pc, if_id_pc4); end
        checks++; if (if_id_rs1 !== m_instr[19:15] || if_id_rs2 !== m_instr[24:20]) begin errors++; $display("FAIL rs_decode: got %0d/%0d exp %0d/%0d", if_id_rs1, if_id_rs2, m_instr[19:15], m_instr[24:20]); end
    endtask

    task automatic test_flush;
        tick(0, 1, 1, 1, 0, 0);
        checks++; if (imem_addr !== 32'h208) begin errors++; $display("FAIL flush_addr: got %h exp %h", imem_addr, 32'h208); end
        checks++; if (if_id_valid !== 1'b0 || if_id_rs1 !== 5'd0 || if_id_rs2 !== 5'd0) begin errors++; $display("FAIL flush_id: got v%b rs %0d/%0d exp v0 0/0", if_id_valid, if_id_rs1, if_id_rs2); end
    endtask

    task automatic test_write_split;
        tick(0, 1, 1, 0, 0, 0);
        tick(0, 1, 0, 0, 0, 0);
        checks++; if (imem_addr !== 32'h210 || if_id_pc !== 32'h208) begin errors++; $display("FAIL pcw_only: got addr %h pc %h exp 210/208", imem_addr, if_id_pc); end
        tick(0, 0, 1, 0, 0, 0);
        tick(0, 0, 1, 0, 0, 0);
        checks++; if (imem_addr !== 32'h210 || if_id_pc !== 32'h210 || if_id_instr !== (32'h210 ^ K)) begin errors++; $display("FAIL idw_only: got addr %h pc %h instr %h exp 210/210/%h", imem_addr, if_id_pc, if_id_instr, 32'h210 ^ K); end
    endtask

    task automatic test_wrap_reset;
        tick(0, 1, 1, 0, 1, 32'hFFFF_FFFE);
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_tgt: got %h exp %h", imem_addr, 32'hFFFF_FFFC); end
        tick(0, 1, 1, 0, 0, 0);
        checks++; if (imem_addr !== 32'h0 || if_id_pc4 !== 32'h0 || if_id_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap: got addr %h pc %h pc4 %h exp 0/fffffffc/0", imem_addr, if_id_pc, if_id_pc4); end
        tick(0, 1, 1, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 1, 32'h40);
        checks++; if (imem_addr !== 32'h0 || if_id_instr !== NOP || if_id_pc !== 32'h0 || if_id_pc4 !== 32'h0 || if_id_valid !== 1'b0) begin errors++; $display("FAIL rst_mid: got addr %h instr %h pc %h pc4 %h v%b exp reset values", imem_addr, if_id_instr, if_id_pc, if_id_pc4, if_id_valid); end
        tick(0, 1, 1, 0, 0, 0);
        checks++; if (imem_addr !== 32'h4 || if_id_valid !== 1'b1 || if_id_pc !== 32'h0) begin errors++; $display("FAIL rst_release: got addr %h v%b pc %h exp 4 v1 0", imem_addr, if_id_valid, if_id_pc); end
    endtask

    task automatic test_random;
        logic [31:0] t;
        for (int i = 0; i < 300; i++) begin
            t = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            tick($urandom_range(0, 30) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, t);
            checks++;
            if (imem_addr !== m_pc || if_id_instr !== m_instr || if_id_pc !== m_idpc || if_id_pc4 !== m_idpc4 ||
                if_id_valid !== m_v || if_id_rs1 !== m_instr[19:15] || if_id_rs2 !== m_instr[24:20]) begin
                errors++;
                $display("FAIL rand[%0d]: got addr %h instr %h pc %h pc4 %h v%b rs %0d/%0d exp addr %h instr %h pc %h pc4 %h v%b",
                         i, imem_addr, if_id_instr, if_id_pc, if_id_pc4, if_id_valid, if_id_rs1, if_id_rs2,
                         m_pc, m_instr, m_idpc, m_idpc4, m_v);
            end
        end
    endtask

    initial begin
        rst = 1'b1; pc_write = 1'b0; if_id_write = 1'b0; if_id_flush = 1'b0;
        branch_taken = 1'b0; branch_target = '0;
        test_reset;
        test_seq_fetch;
        test_stall;
        test_branch;
        test_stall_branch;
        test_flush;
        test_write_split;
        test_wrap_reset;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
